// File: rtl/mux9_rr_sel_arbiter.sv
// mux9_rr_sel_arbiter
//
// Round-robin burst arbiter that drives the 4-bit select of a 16-bit 9-to-1 mux.
// It grants one of nine requesting sources and holds sel for up to BURST_MAX
// accepted valid/ready beats. Each accepted beat returns a one-hot pop to the
// granted source. When idle, sel parks at 4'hF so the mux outputs its all-ones
// idle value.
//
// Parameters:
//   BURST_MAX  - maximum accepted beats per grant (1..16)
//
// Ports:
//   clk        - clock, rising edge
//   areset     - asynchronous active-high reset
//   req[8:0]   - per-source data available (bit n = mux input n)
//   ready      - downstream accepts the current beat
//   sel[3:0]   - registered mux select, 0..8, or 4'hF when idle
//   out_valid  - muxed data is a valid beat
//   pop[8:0]   - one-hot dequeue strobe to the granted source, one per accepted beat
//   beat_count - saturating count of accepted beats (only with MUX9_ARB_STATS_EN)
//
// Optional feature macro: MUX9_ARB_STATS_EN adds the beat_count output and its counter.

module mux9_rr_sel_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [8:0]  req,
  input  logic        ready,
  output logic [3:0]  sel,
  output logic        out_valid,
  output logic [8:0]  pop
`ifdef MUX9_ARB_STATS_EN
  ,
  output logic [15:0] beat_count
`endif
);

  localparam logic [3:0] SelIdle  = 4'hF;
  localparam logic [3:0] PtrReset = 4'd8;
  localparam logic [3:0] CntLast  = 4'(BURST_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] ptr_q, ptr_d;

  logic [8:0] sel_oh;
  logic       req_sel;
  logic       accept;
  logic       pick_any;
  logic [3:0] pick_idx;
  logic [4:0] cand;

  // Out-of-range sel (idle value 4'hF) shifts the one out of the 9-bit vector.
  assign sel_oh  = 9'b1 << sel_q;
  assign req_sel = |(req & sel_oh);

  // Search ptr+1, ptr+2, ... modulo 9. Iterating from the far end means the
  // nearest requester is the last one written and therefore wins.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    pick_any = |req;
    for (int i = 9; i >= 1; i--) begin
      cand = {1'b0, ptr_q} + 5'(i);
      if (cand >= 5'd9) begin
        cand = cand - 5'd9;
      end
      if (req[cand[3:0]]) begin
        pick_idx = cand[3:0];
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    accept    = 1'b0;
    pop       = '0;
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StGrant;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        out_valid = req_sel;
        accept    = req_sel & ready;
        pop       = accept ? sel_oh : '0;
        if (!req_sel || (accept && cnt_q == CntLast)) begin
          state_d = StIdle;
          sel_d   = SelIdle;
          ptr_d   = sel_q;
        end else if (accept) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = SelIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      sel_q   <= SelIdle;
      cnt_q   <= '0;
      ptr_q   <= PtrReset;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel = sel_q;

`ifdef MUX9_ARB_STATS_EN
  logic [15:0] beat_count_q, beat_count_d;

  always_comb begin
    beat_count_d = beat_count_q;
    if (accept && beat_count_q != 16'hFFFF) begin
      beat_count_d = beat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      beat_count_q <= '0;
    end else begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;
`endif

endmodule
